// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encoding and width constants shared by the
// universal shift register and its mode decoder.
package univ_shift_reg_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/univ_shift_reg_mode_dec.sv
// usr_mode_dec: combinational decode of {s1,s0} into one-hot
// hold/shr/shl/load strobes.
module usr_mode_dec
    import univ_shift_reg_pkg::*;
(
    input  logic s1,
    input  logic s0,
    output logic hold,
    output logic shr,
    output logic shl,
    output logic load
);

    mode_e mode;

    always_comb begin
        mode = mode_e'({s1, s0});
        hold = mode == MODE_HOLD;
        shr  = mode == MODE_SHR;
        shl  = mode == MODE_SHL;
        load = mode == MODE_LOAD;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: 4-bit universal shift register (hold/shift-right/shift-left/load)
// with mode-change pulse; shift counter present when SHIFT_COUNT_EN is defined.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             s0,
    input  logic             s1,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             sr_in,
    input  logic             sl_in,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             mode_chg
`ifdef SHIFT_COUNT_EN
    ,
    output logic [CNT_W-1:0] shift_cnt
`endif
);

    logic hold, shr, shl, load;
    logic [WIDTH-1:0] q_nxt;
    logic so_r_nxt, so_l_nxt;
    mode_e mode;

    usr_mode_dec u_dec (
        .s1   (s1),
        .s0   (s0),
        .hold (hold),
        .shr  (shr),
        .shl  (shl),
        .load (load)
    );

    always_comb begin
        q_nxt    = hold ? q
                 : load ? d
                 : shr  ? {sr_in, q[WIDTH-1:1]}
                 :        {q[WIDTH-2:0], sl_in};
        so_r_nxt = shr ? q[0] : so_r;
        so_l_nxt = shl ? q[WIDTH-1] : so_l;
    end

    // mode_chg compares against the mode captured on the previous enabled edge
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            so_r     <= 1'b0;
            so_l     <= 1'b0;
            mode     <= MODE_HOLD;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= en && (mode_e'({s1, s0}) != mode);
            if (en) begin
                mode <= mode_e'({s1, s0});
                q    <= q_nxt;
                so_r <= so_r_nxt;
                so_l <= so_l_nxt;
            end
        end
    end

`ifdef SHIFT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            shift_cnt <= '0;
        else if (en)
            shift_cnt <= load ? '0
                       : ((shr || shl) && shift_cnt != CNT_MAX) ? shift_cnt + 1'b1
                       : shift_cnt;
    end
`endif

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, a synchronous active-high clear, driven by the upstream control circuit's `reset`.
REQ-003 The block SHALL have the port `s0`: input, 1 bit, mode select LSB, driven by the upstream control circuit.
REQ-004 The block SHALL have the port `s1`: input, 1 bit, mode select MSB, driven by the upstream control circuit.
REQ-005 The block SHALL have the port `en`: input, 1 bit, the update enable; when 0, all registers hold.
REQ-006 The block SHALL have the port `d`: input, 4 bits, parallel load data.
REQ-007 The block SHALL have the port `sr_in`: input, 1 bit, serial input for shift-right; enters at `q[3]`.
REQ-008 The block SHALL have the port `sl_in`: input, 1 bit, serial input for shift-left; enters at `q[0]`.
REQ-009 The block SHALL have the port `q`: output, 4 bits, the register contents.
REQ-010 The block SHALL have the port `so_r`: output, 1 bit, the bit shifted out on the last shift-right (the previous `q[0]`).
REQ-011 The block SHALL have the port `so_l`: output, 1 bit, the bit shifted out on the last shift-left (the previous `q[3]`).
REQ-012 The block SHALL have the port `mode_chg`: output, 1 bit, a one-cycle pulse when the registered mode differs from the previous registered mode.
REQ-013 The block SHALL have the port `shift_cnt`: output, 4 bits, the count of shifts since the last load or reset (present only when `SHIFT_COUNT_EN` is defined).

Function
REQ-014 {s1,s0} SHALL be decoded as: 00 = HOLD, 01 = SHR, 10 = SHL, 11 = LOAD.
REQ-015 HOLD SHALL leave `q`, `so_r` and `so_l` unchanged.
REQ-016 SHR SHALL set q <= {sr_in, q[3:1]} and so_r <= q[0] in the same edge; `so_l` holds.
REQ-017 SHL SHALL set q <= {q[2:0], sl_in} and so_l <= q[3]; `so_r` holds.
REQ-018 LOAD SHALL set q <= d with one-cycle latency; `so_r` and `so_l` hold.
REQ-019 With en=0, `q`, `so_r`, `so_l`, `shift_cnt` and the mode register SHALL hold regardless of {s1,s0}.
REQ-020 The mode register SHALL capture {s1,s0} on every edge with en=1.
REQ-021 `mode_chg` SHALL be 1 for exactly one cycle after an enabled edge whose captured mode differs from the previously captured mode, and 0 otherwise.
REQ-022 The first enabled edge after reset SHALL compare against HOLD (00).
REQ-023 `shift_cnt` SHALL increment by 1 on each enabled SHR or SHL edge, saturating at 15 (no wrap).
REQ-024 `shift_cnt` SHALL clear to 0 on an enabled LOAD and hold on HOLD.
REQ-025 Mode inputs changing every cycle SHALL take effect per edge with no settling cycle.
REQ-026 The block SHALL behave as a purely synchronous design, with no combinational path from inputs to outputs.

Reset
REQ-027 reset=1 at a rising edge SHALL force q=0000, so_r=0, so_l=0, mode register=00, mode_chg=0 and shift_cnt=0.
REQ-028 `reset` SHALL take priority over `en` and all modes.
REQ-029 Reset asserted mid-shift-sequence SHALL abort the sequence with no residual state; the next enabled edge behaves as from power-up.

Configuration
REQ-030 The macro `SHIFT_COUNT_EN`, when defined, SHALL include the `shift_cnt` port and its counter logic per REQ-023 and REQ-024.
REQ-031 When `SHIFT_COUNT_EN` is undefined, the `shift_cnt` port and its counter SHALL be absent, with all other behaviour unchanged.

Structure
REQ-032 A shared package SHALL hold the 2-bit mode constants MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD and the register width constant (4).
REQ-033 A sub-module `usr_mode_dec` SHALL decode {s1,s0} into one-hot hold/shr/shl/load strobes, combinationally.
REQ-034 All storage SHALL reside in `univ_shift_reg`.

Verification
REQ-035 Reset, then LOAD d=1011 with en=1 SHALL give q=1011 after 1 cycle, shift_cnt=0 and mode_chg=1.
REQ-036 From q=1011, 3x SHR with sr_in=0 SHALL give q=0101, 0010, 0001 in turn, so_r=1, 1, 0, and shift_cnt=3.
REQ-037 From q=0001, 4x SHL with sl_in=1 SHALL give q=0011, 0111, 1111, 1111, so_l=0, 0, 0, 1, and shift_cnt=7.
REQ-038 Holding SHR for 20 cycles SHALL saturate shift_cnt at 15, and a following LOAD d=0110 SHALL give shift_cnt=0 and q=0110.
REQ-039 en=0 with mode SHL for 5 cycles SHALL hold q and shift_cnt with mode_chg=0; re-enabling with SHL SHALL pulse mode_chg only if the prior captured mode differs.
REQ-040 reset=1 asserted together with en=1 and LOAD d=1111 SHALL give q=0000, shift_cnt=0 and mode_chg=0 on the next edge.
